pc_sequencer: RTL and testbench

//  Next-PC controller for the program_counter datapath block: per cycle, chooses its select (ps) and operand (in).

---
 rtl/pc_sequencer_pkg.sv | 44 ++++
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/pc_sequencer_cond_eval.sv | 33 +++
 rtl/pc_sequencer.sv | 125 ++++++++++++
 tb/tb_pc_sequencer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the next-PC sequencer: program_counter selects, branch types,
// condition codes and sequencer states.
package pc_sequencer_pkg;

    localparam int unsigned CNT_W = 2;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_LOAD = 2'b10;
    localparam logic [1:0] PS_ADD  = 2'b11;

    localparam logic [2:0] BR_NONE  = 3'd0;
    localparam logic [2:0] BR_B     = 3'd1;
    localparam logic [2:0] BR_CBZ   = 3'd2;
    localparam logic [2:0] BR_CBNZ  = 3'd3;
    localparam logic [2:0] BR_BCOND = 3'd4;
    localparam logic [2:0] BR_BR    = 3'd5;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_HS = 4'd2;
    localparam logic [3:0] COND_LO = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_RUN,
        ST_WAIT,
        ST_FLUSH,
        ST_HALT
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode/flag inputs and program_counter control outputs of the next-PC sequencer.
interface pc_sequencer_if #(parameter int unsigned PC_WIDTH = 64);
    logic                instr_valid;
    logic [2:0]          br_type;
    logic [3:0]          cond;
    logic [3:0]          nzcv;
    logic                reg_zero;
    logic [PC_WIDTH-1:0] br_offset;
    logic [PC_WIDTH-1:0] br_target;
    logic                imem_ready;
    logic                halt_req;
    logic [1:0]          ps;
    logic [PC_WIDTH-1:0] pc_in;
    logic                flush;
    logic                halted;

    modport master (
        output instr_valid, br_type, cond, nzcv, reg_zero, br_offset, br_target,
               imem_ready, halt_req,
        input  ps, pc_in, flush, halted
    );

    modport slave (
        input  instr_valid, br_type, cond, nzcv, reg_zero, br_offset, br_target,
               imem_ready, halt_req,
        output ps, pc_in, flush, halted
    );
endinterface

// File: rtl/pc_sequencer_cond_eval.sv
// Combinational condition-code evaluator: {cond, nzcv} -> condition passes.
module pc_sequencer_cond_eval
    import pc_sequencer_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_nzcv,
    output logic       o_pass_c
);
    logic w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = i_nzcv;

    always_comb begin
        o_pass_c = 1'b1;
        case (i_cond)
            COND_EQ:          o_pass_c = w_z;
            COND_NE:          o_pass_c = ~w_z;
            COND_HS:          o_pass_c = w_c;
            COND_LO:          o_pass_c = ~w_c;
            COND_MI:          o_pass_c = w_n;
            COND_PL:          o_pass_c = ~w_n;
            COND_VS:          o_pass_c = w_v;
            COND_VC:          o_pass_c = ~w_v;
            COND_HI:          o_pass_c = w_c & ~w_z;
            COND_LS:          o_pass_c = ~(w_c & ~w_z);
            COND_GE:          o_pass_c = (w_n == w_v);
            COND_LT:          o_pass_c = (w_n != w_v);
            COND_GT:          o_pass_c = ~w_z & (w_n == w_v);
            COND_LE:          o_pass_c = ~(~w_z & (w_n == w_v));
            COND_AL, COND_NV: o_pass_c = 1'b1;
        endcase
    end
endmodule

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: chooses program_counter select/operand, handles fetch stalls, flush, halt.
// Optional PC_SEQ_STATS_EN adds o_taken_count (saturating count of taken branches issued).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned PC_WIDTH     = 64,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic          i_clock,
    input  logic          i_reset,
    pc_sequencer_if.slave bus
`ifdef PC_SEQ_STATS_EN
    ,
    output logic [31:0]   o_taken_count
`endif
);
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES);

    seq_state_e          r_state;
    logic [1:0]          r_ps;
    logic [PC_WIDTH-1:0] r_pc_in;
    logic                r_flush;
    logic                r_halted;
    logic [CNT_W-1:0]    r_cnt;

    logic w_cond_pass;
    logic w_take_rel;
    logic w_take_abs;
    logic w_issue;

    pc_sequencer_cond_eval u_cond_eval (
        .i_cond   (bus.cond),
        .i_nzcv   (bus.nzcv),
        .o_pass_c (w_cond_pass)
    );

    // Branch resolution: relative (pc+offset) vs absolute (load target)
    always_comb begin
        w_take_rel = 1'b0;
        w_take_abs = 1'b0;
        if (bus.instr_valid) begin
            case (bus.br_type)
                BR_NONE:  ;
                BR_B:     w_take_rel = 1'b1;
                BR_CBZ:   w_take_rel = bus.reg_zero;
                BR_CBNZ:  w_take_rel = ~bus.reg_zero;
                BR_BCOND: w_take_rel = w_cond_pass;
                BR_BR:    w_take_abs = 1'b1;
                default:  ;
            endcase
        end
    end

    assign w_issue = ((r_state == ST_RUN) || (r_state == ST_WAIT)) && !bus.halt_req
                     && bus.imem_ready && (w_take_rel || w_take_abs);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= ST_INIT;
            r_ps     <= PS_HOLD;
            r_pc_in  <= '0;
            r_flush  <= 1'b0;
            r_halted <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_ps    <= PS_HOLD;
            r_pc_in <= '0;
            r_flush <= 1'b0;
            case (r_state)
                ST_INIT: r_state <= ST_RUN;
                // WAIT re-evaluates exactly like RUN once the fetch side is ready
                ST_RUN, ST_WAIT: begin
                    if (bus.halt_req) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else if (!bus.imem_ready) begin
                        r_state <= ST_WAIT;
                    end else if (w_issue) begin
                        r_ps    <= w_take_abs ? PS_LOAD : PS_ADD;
                        r_pc_in <= w_take_abs ? bus.br_target : bus.br_offset;
                        r_cnt   <= FLUSH_INIT;
                        r_state <= ST_FLUSH;
                    end else begin
                        r_ps    <= PS_INC;
                        r_state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (bus.halt_req) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_flush <= 1'b1;
                        if (bus.imem_ready) begin
                            r_ps  <= PS_INC;
                            r_cnt <= r_cnt - 1'b1;
                            if (r_cnt == CNT_W'(1)) r_state <= ST_RUN;
                        end
                    end
                end
                ST_HALT: r_halted <= 1'b1;
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign bus.ps     = r_ps;
    assign bus.pc_in  = r_pc_in;
    assign bus.flush  = r_flush;
    assign bus.halted = r_halted;

`ifdef PC_SEQ_STATS_EN
    logic [31:0] r_taken_count;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_taken_count <= '0;
        end else if (w_issue && (r_taken_count != 32'hFFFF_FFFF)) begin
            r_taken_count <= r_taken_count + 32'd1;
        end
    end

    assign o_taken_count = r_taken_count;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (FLUSH_CYCLES 1 and 3) share stimulus and are
// compared against a cycle-level reference model; PC_SEQ_STATS_EN adds taken_count checks.
module tb_pc_sequencer;
    localparam int unsigned PW = 64;
    localparam int M_INIT = 0, M_RUN = 1, M_FLUSH = 2, M_HALT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          instr_valid, reg_zero, imem_ready, halt_req;
    logic [2:0]    br_type;
    logic [3:0]    cond, nzcv;
    logic [PW-1:0] br_offset, br_target;

    pc_sequencer_if #(.PC_WIDTH(PW)) bus1 ();
    pc_sequencer_if #(.PC_WIDTH(PW)) bus3 ();

    assign bus1.instr_valid = instr_valid;  assign bus3.instr_valid = instr_valid;
    assign bus1.br_type     = br_type;      assign bus3.br_type     = br_type;
    assign bus1.cond        = cond;         assign bus3.cond        = cond;
    assign bus1.nzcv        = nzcv;         assign bus3.nzcv        = nzcv;
    assign bus1.reg_zero    = reg_zero;     assign bus3.reg_zero    = reg_zero;
    assign bus1.br_offset   = br_offset;    assign bus3.br_offset   = br_offset;
    assign bus1.br_target   = br_target;    assign bus3.br_target   = br_target;
    assign bus1.imem_ready  = imem_ready;   assign bus3.imem_ready  = imem_ready;
    assign bus1.halt_req    = halt_req;     assign bus3.halt_req    = halt_req;

`ifdef PC_SEQ_STATS_EN
    logic [31:0] tc [2];
`endif

    pc_sequencer #(.PC_WIDTH(PW), .FLUSH_CYCLES(1)) dut1 (
        .i_clock(clk), .i_reset(rst), .bus(bus1)
`ifdef PC_SEQ_STATS_EN
        , .o_taken_count(tc[0])
`endif
    );

    pc_sequencer #(.PC_WIDTH(PW), .FLUSH_CYCLES(3)) dut3 (
        .i_clock(clk), .i_reset(rst), .bus(bus3)
`ifdef PC_SEQ_STATS_EN
        , .o_taken_count(tc[1])
`endif
    );

    logic [3:0]    obs    [2];
    logic [PW-1:0] obs_pc [2];
    assign obs[0]    = {bus1.ps, bus1.flush, bus1.halted};
    assign obs[1]    = {bus3.ps, bus3.flush, bus3.halted};
    assign obs_pc[0] = bus1.pc_in;
    assign obs_pc[1] = bus3.pc_in;

    int checks = 0;
    int errors = 0;

    // Reference model state, one slot per instance
    int            m_mode  [2];
    int            m_left  [2];
    int            m_fc    [2] = '{1, 3};
    longint        m_count [2];
    logic [3:0]    e_obs   [2];
    logic [PW-1:0] e_pc    [2];
    bit            e_pc_chk[2];

    function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (int'(c))
            0:  return z;
            1:  return !z;
            2:  return cy;
            3:  return !cy;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return cy && !z;
            9:  return !(cy && !z);
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return !(!z && (n == v));
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit ref_taken();
        if (!instr_valid) return 1'b0;
        case (int'(br_type))
            1: return 1'b1;
            2: return reg_zero;
            3: return !reg_zero;
            4: return ref_cond(cond, nzcv);
            5: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_INIT; m_left[i] = 0; m_count[i] = 0;
            e_obs[i] = 4'b0000; e_pc[i] = '0; e_pc_chk[i] = 1'b1;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic [1:0] ps;
            bit fl;
            ps = 2'd0; fl = 1'b0; e_pc[i] = '0; e_pc_chk[i] = 1'b0;
            if (m_mode[i] == M_INIT) begin
                m_mode[i] = M_RUN;
            end else if (m_mode[i] == M_RUN) begin
                if (halt_req) m_mode[i] = M_HALT;
                else if (!imem_ready) ps = 2'd0;
                else if (ref_taken()) begin
                    ps = (br_type == 3'd5) ? 2'd2 : 2'd3;
                    e_pc[i] = (br_type == 3'd5) ? br_target : br_offset;
                    e_pc_chk[i] = 1'b1;
                    m_mode[i] = M_FLUSH;
                    m_left[i] = m_fc[i];
                    if (m_count[i] < 64'hFFFF_FFFF) m_count[i]++;
                end else begin
                    ps = 2'd1;
                    e_pc_chk[i] = 1'b1;
                end
            end else if (m_mode[i] == M_FLUSH) begin
                if (halt_req) m_mode[i] = M_HALT;
                else begin
                    fl = 1'b1;
                    if (imem_ready) begin
                        ps = 2'd1;
                        m_left[i]--;
                        if (m_left[i] == 0) m_mode[i] = M_RUN;
                    end
                end
            end
            e_obs[i] = {ps, fl, (m_mode[i] == M_HALT)};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0; br_type = 3'd0; cond = 4'd0; nzcv = 4'd0; reg_zero = 1'b0;
        br_offset = '0; br_target = '0; imem_ready = 1'b1; halt_req = 1'b0;
    endtask

    task automatic random_inputs();
        instr_valid = 1'($urandom_range(0, 3) != 0);
        br_type     = 3'($urandom_range(0, 7));
        cond        = 4'($urandom_range(0, 15));
        nzcv        = 4'($urandom_range(0, 15));
        reg_zero    = 1'($urandom_range(0, 1));
        br_offset   = {32'($urandom), 32'($urandom)};
        br_target   = {32'($urandom), 32'($urandom)};
        imem_ready  = 1'($urandom_range(0, 4) != 0);
        halt_req    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== 4'b0000) begin
                errors++; $display("FAIL reset inst%0d {ps,flush,halted} got %b want 0000", i, obs[i]);
            end
            checks++;
            if (obs_pc[i] !== '0) begin
                errors++; $display("FAIL reset_pc inst%0d got %h want 0", i, obs_pc[i]);
            end
        end
    endtask

    task automatic test_idle();
        logic [1:0] want [4] = '{2'b00, 2'b01, 2'b01, 2'b01};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (obs[0] !== {want[k], 2'b00}) begin
                errors++; $display("FAIL idle[%0d] {ps,flush,halted} got %b want %b", k, obs[0], {want[k], 2'b00});
            end
        end
    endtask

    task automatic test_branch_b();
        logic [1:0] want_ps [3] = '{2'b11, 2'b01, 2'b01};
        logic       want_fl [3] = '{1'b0, 1'b1, 1'b0};
        instr_valid = 1'b1; br_type = 3'd1; br_offset = 64'h30;
        for (int k = 0; k < 3; k++) begin
            tick();
            idle_inputs();
            checks++;
            if ({bus1.ps, bus1.flush} !== {want_ps[k], want_fl[k]}) begin
                errors++; $display("FAIL branch_b[%0d] {ps,flush} got %b want %b", k, {bus1.ps, bus1.flush}, {want_ps[k], want_fl[k]});
            end
            if (k == 0) begin
                checks++;
                if (bus1.pc_in !== 64'h30) begin
                    errors++; $display("FAIL branch_b_pc got %h want 30", bus1.pc_in);
                end
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== e_obs[i]) begin
                    errors++; $display("FAIL branch_b_model[%0d] inst%0d got %b want %b", k, i, obs[i], e_obs[i]);
                end
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_wait_br();
        instr_valid = 1'b1; br_type = 3'd5; br_target = 64'h10; imem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) imem_ready = 1'b1;
            tick();
            checks++;
            if (bus1.ps !== ((k == 3) ? 2'b10 : 2'b00)) begin
                errors++; $display("FAIL wait_br[%0d] ps got %b want %b", k, bus1.ps, (k == 3) ? 2'b10 : 2'b00);
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== e_obs[i] || (e_pc_chk[i] && obs_pc[i] !== e_pc[i])) begin
                    errors++; $display("FAIL wait_br_model[%0d] inst%0d got %b/%h want %b/%h", k, i, obs[i], obs_pc[i], e_obs[i], e_pc[i]);
                end
            end
        end
        checks++;
        if (bus1.pc_in !== 64'h10) begin
            errors++; $display("FAIL wait_br_pc got %h want 10", bus1.pc_in);
        end
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic test_bcond();
        logic [3:0] flags [2];
        instr_valid = 1'b1; br_type = 3'd4; cond = 4'd10; br_offset = 64'h40;
        nzcv = 4'b1001; tick();
        checks++;
        if (bus1.ps !== 2'b11) begin
            errors++; $display("FAIL bcond_ge_taken ps got %b want 11", bus1.ps);
        end
        idle_inputs(); repeat (4) tick();
        instr_valid = 1'b1; br_type = 3'd4; cond = 4'd10; nzcv = 4'b1000; tick();
        checks++;
        if (bus1.ps !== 2'b01) begin
            errors++; $display("FAIL bcond_ge_not_taken ps got %b want 01", bus1.ps);
        end
        idle_inputs(); repeat (4) tick();
        for (int c = 0; c < 16; c++) begin
            flags[0] = 4'($urandom_range(0, 15));
            flags[1] = ~flags[0];
            for (int f = 0; f < 2; f++) begin
                instr_valid = 1'b1; br_type = 3'd4; cond = 4'(c); nzcv = flags[f];
                br_offset = {32'($urandom), 32'($urandom)};
                tick();
                idle_inputs();
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (obs[i] !== e_obs[i] || (e_pc_chk[i] && obs_pc[i] !== e_pc[i])) begin
                        errors++; $display("FAIL bcond_sweep cond=%0d nzcv=%b inst%0d got %b/%h want %b/%h", c, flags[f], i, obs[i], obs_pc[i], e_obs[i], e_pc[i]);
                    end
                end
                repeat (4) tick();
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            random_inputs();
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== e_obs[i] || (e_pc_chk[i] && obs_pc[i] !== e_pc[i])) begin
                    errors++; $display("FAIL random[%0d] inst%0d got %b/%h want %b/%h", k, i, obs[i], obs_pc[i], e_obs[i], e_pc[i]);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (2) tick();
        instr_valid = 1'b1; br_type = 3'd1; br_offset = 64'h100;
        tick();
        idle_inputs();
        tick();
        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== 4'b0000 || obs_pc[i] !== '0) begin
                errors++; $display("FAIL async_reset inst%0d got %b/%h want 0000/0", i, obs[i], obs_pc[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== e_obs[i]) begin
                    errors++; $display("FAIL async_reset_after[%0d] inst%0d got %b want %b", k, i, obs[i], e_obs[i]);
                end
            end
        end
    endtask

    task automatic test_halt_in_flush();
        do_reset();
        repeat (2) tick();
        instr_valid = 1'b1; br_type = 3'd1; br_offset = 64'h20;
        tick();
        idle_inputs();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== 4'b0001) begin
                errors++; $display("FAIL halt_in_flush inst%0d {ps,flush,halted} got %b want 0001", i, obs[i]);
            end
        end
        for (int k = 0; k < 10; k++) begin
            random_inputs();
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== e_obs[i]) begin
                    errors++; $display("FAIL halt_stays[%0d] inst%0d got %b want %b", k, i, obs[i], e_obs[i]);
                end
            end
        end
        idle_inputs();
    endtask

`ifdef PC_SEQ_STATS_EN
    task automatic test_stats();
        bit take [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        repeat (2) tick();
        for (int k = 0; k < 8; k++) begin
            instr_valid = 1'b1; br_type = 3'd2; reg_zero = take[k];
            tick();
            idle_inputs();
            repeat (4) tick();
        end
        checks++;
        if (tc[0] !== 32'd5 || tc[1] !== 32'd5) begin
            errors++; $display("FAIL stats_count got %0d/%0d want 5", tc[0], tc[1]);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (64'(tc[i]) !== m_count[i]) begin
                errors++; $display("FAIL stats_model inst%0d got %0d want %0d", i, tc[i], m_count[i]);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (tc[0] !== 32'd0 || tc[1] !== 32'd0) begin
            errors++; $display("FAIL stats_reset got %0d/%0d want 0", tc[0], tc[1]);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_idle();
        test_branch_b();
        test_wait_br();
        test_bcond();
        test_random();
        test_async_reset();
`ifdef PC_SEQ_STATS_EN
        test_stats();
`endif
        test_halt_in_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
